// File: rtl/pipeline_ctrl_sequencer.sv
// Pipeline-control sequencer: arbitrates stall, mispredict and memory-wait requests into PC/IF/ID/ID/EX enables and flushes.
// Stage controls are combinational (same cycle); boot_cnt, state and event counters are registered.
module pipeline_ctrl_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_ctrl,
  input  logic             stall_cnt,
  input  logic             mispredict,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic [1:0]       boot_cnt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_events,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_WAIT_MEM = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       boot_cnt_q, boot_cnt_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             pending_mp_q, pending_mp_d;
  logic [CNT_W-1:0] stall_events_q, stall_events_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_flush_c;
  logic run_eval, mp_eff, stall_inc, flush_inc;

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = (boot_cnt_q == 2'd3) ? 2'd3 : boot_cnt_q + 2'd1;
    flush_cnt_d   = flush_cnt_q;
    pending_mp_d  = pending_mp_q;
    pc_en_c       = 1'b0;
    if_id_en_c    = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    run_eval      = 1'b0;
    mp_eff        = mispredict;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        id_ex_flush_c = 1'b1;
        if (boot_cnt_q != 2'd0) state_d = ST_RUN;
      end
      ST_RUN: run_eval = 1'b1;
      ST_FLUSH: begin
        // Wrong-path requests are dropped here; only a memory wait can pause the flush.
        if (!mem_busy) begin
          pc_en_c       = 1'b1;
          if_id_en_c    = 1'b1;
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          flush_cnt_d   = flush_cnt_q - 4'd1;
          if (flush_cnt_q <= 4'd1) state_d = ST_RUN;
        end
      end
      ST_WAIT_MEM: begin
        if (mem_busy) begin
          if (mispredict) pending_mp_d = 1'b1;
        end else begin
          run_eval     = 1'b1;
          mp_eff       = mispredict | pending_mp_q;
          pending_mp_d = 1'b0;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (run_eval) begin
      if (mp_eff) begin
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        flush_inc     = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 4'(FLUSH_CYCLES - 1);
        end else begin
          state_d = ST_RUN;
        end
      end else if (mem_busy) begin
        state_d = ST_WAIT_MEM;
      end else if (stall_ctrl) begin
        id_ex_flush_c = 1'b1;
        stall_inc     = stall_cnt;
        state_d       = ST_RUN;
      end else begin
        pc_en_c    = 1'b1;
        if_id_en_c = 1'b1;
        state_d    = ST_RUN;
      end
    end

    stall_events_d = cnt_clr ? '0 : stall_events_q + CNT_W'(stall_inc);
    flush_events_d = cnt_clr ? '0 : flush_events_q + CNT_W'(flush_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_BOOT;
      boot_cnt_q     <= 2'd0;
      flush_cnt_q    <= 4'd0;
      pending_mp_q   <= 1'b0;
      stall_events_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      boot_cnt_q     <= boot_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      pending_mp_q   <= pending_mp_d;
      stall_events_q <= stall_events_d;
      flush_events_q <= flush_events_d;
    end
  end

  // Reset holds the pipe frozen and filled with bubbles.
  assign pc_en        = rst ? 1'b0 : pc_en_c;
  assign if_id_en     = rst ? 1'b0 : if_id_en_c;
  assign if_id_flush  = rst ? 1'b1 : if_id_flush_c;
  assign id_ex_flush  = rst ? 1'b1 : id_ex_flush_c;
  assign boot_cnt     = boot_cnt_q;
  assign ctrl_state   = state_q;
  assign stall_events = stall_events_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// Scoreboard bench for pipeline_ctrl_sequencer: per-cycle expectations queued at drive time, checked at negedge.
module tb_pipeline_ctrl_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_ctrl, stall_cnt, mispredict, mem_busy, cnt_clr;
  logic [1:0]  boot_cnt;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_events, flush_events;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [3:0]  stg;   // {pc_en, if_id_en, if_id_flush, id_ex_flush}
    logic [1:0]  st;
    logic [1:0]  boot;
    logic [15:0] sev;
    logic [15:0] fev;
  } exp_t;

  exp_t sb_q[$];

  pipeline_ctrl_sequencer #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_ctrl   (stall_ctrl),
    .stall_cnt    (stall_cnt),
    .mispredict   (mispredict),
    .mem_busy     (mem_busy),
    .cnt_clr      (cnt_clr),
    .boot_cnt     (boot_cnt),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ctrl_state   (ctrl_state),
    .stall_events (stall_events),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, ".stg"},   {28'd0, pc_en, if_id_en, if_id_flush, id_ex_flush}, {28'd0, e.stg});
      chk({e.tag, ".state"}, {30'd0, ctrl_state}, {30'd0, e.st});
      chk({e.tag, ".boot"},  {30'd0, boot_cnt},   {30'd0, e.boot});
      chk({e.tag, ".sev"},   {16'd0, stall_events}, {16'd0, e.sev});
      chk({e.tag, ".fev"},   {16'd0, flush_events}, {16'd0, e.fev});
    end
  end

  // Drive one cycle of stimulus (called #1 after a posedge) and queue what that cycle must show.
  task automatic cyc(input string tag, input bit r, input bit sc, input bit scnt, input bit mp,
                     input bit mb, input bit clr, input logic [3:0] stg, input logic [1:0] st,
                     input logic [1:0] boot, input int sev, input int fev);
    exp_t e;
    rst        = r;
    stall_ctrl = sc;
    stall_cnt  = scnt;
    mispredict = mp;
    mem_busy   = mb;
    cnt_clr    = clr;
    e.tag  = tag;
    e.stg  = stg;
    e.st   = st;
    e.boot = boot;
    e.sev  = 16'(sev);
    e.fev  = 16'(fev);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, FLSH = 2'd2, WAIT = 2'd3;

  initial begin
    int guard;
    rst = 1'b1; stall_ctrl = 0; stall_cnt = 0; mispredict = 0; mem_busy = 0; cnt_clr = 0;
    @(posedge clk);
    #1;
    //      tag        r sc sn mp mb cl stg    st    bt sev fev
    cyc("rst",         1, 0, 0, 0, 0, 0, 4'h3, BOOT, 0, 0, 0);
    cyc("boot0",       0, 0, 0, 0, 0, 0, 4'hD, BOOT, 0, 0, 0);
    cyc("boot1",       0, 0, 0, 0, 0, 0, 4'hD, BOOT, 1, 0, 0);
    cyc("boot2",       0, 0, 0, 0, 0, 0, 4'hC, RUN,  2, 0, 0);
    cyc("boot3",       0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 0, 0);
    cyc("boot_sat",    0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 0, 0);
    cyc("stall",       0, 1, 1, 0, 0, 0, 4'h1, RUN,  3, 0, 0);
    cyc("stall_post",  0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 1, 0);
    cyc("stall_nocnt", 0, 1, 0, 0, 0, 0, 4'h1, RUN,  3, 1, 0);
    cyc("nocnt_post",  0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 1, 0);
    cyc("cnt_only",    0, 0, 1, 0, 0, 0, 4'hC, RUN,  3, 1, 0);
    cyc("cnt_only_p",  0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 1, 0);
    cyc("mp",          0, 0, 0, 1, 0, 0, 4'hF, RUN,  3, 1, 0);
    cyc("mp_flush",    0, 0, 0, 0, 0, 0, 4'hF, FLSH, 3, 1, 1);
    cyc("mp_run",      0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 1, 1);
    cyc("all_req",     0, 1, 1, 1, 1, 0, 4'hF, RUN,  3, 1, 1);
    cyc("flush_ign",   0, 1, 1, 1, 0, 0, 4'hF, FLSH, 3, 1, 2);
    cyc("ign_post",    0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 1, 2);
    cyc("mp2",         0, 0, 0, 1, 0, 0, 4'hF, RUN,  3, 1, 2);
    cyc("flush_mb1",   0, 0, 0, 0, 1, 0, 4'h0, FLSH, 3, 1, 3);
    cyc("flush_mb2",   0, 0, 0, 0, 1, 0, 4'h0, FLSH, 3, 1, 3);
    cyc("flush_rel",   0, 0, 0, 0, 0, 0, 4'hF, FLSH, 3, 1, 3);
    cyc("flush_done",  0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 1, 3);
    cyc("mb1",         0, 0, 0, 0, 1, 0, 4'h0, RUN,  3, 1, 3);
    cyc("mb2",         0, 0, 0, 0, 1, 0, 4'h0, WAIT, 3, 1, 3);
    cyc("mb3_mp",      0, 0, 0, 1, 1, 0, 4'h0, WAIT, 3, 1, 3);
    cyc("mb_rel",      0, 0, 0, 0, 0, 0, 4'hF, WAIT, 3, 1, 3);
    cyc("rel_flush",   0, 0, 0, 0, 0, 0, 4'hF, FLSH, 3, 1, 4);
    cyc("rel_run",     0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 1, 4);
    cyc("mb_st",       0, 0, 0, 0, 1, 0, 4'h0, RUN,  3, 1, 4);
    cyc("rel_stall",   0, 1, 1, 0, 0, 0, 4'h1, WAIT, 3, 1, 4);
    cyc("rel_st_post", 0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 2, 4);
    cyc("clr_stall",   0, 1, 1, 0, 0, 1, 4'h1, RUN,  3, 2, 4);
    cyc("clr_post",    0, 0, 0, 0, 0, 0, 4'hC, RUN,  3, 0, 0);
    cyc("mp3",         0, 0, 0, 1, 0, 0, 4'hF, RUN,  3, 0, 0);
    cyc("rst_flush",   1, 0, 0, 0, 0, 0, 4'h3, FLSH, 3, 0, 1);
    cyc("reboot0",     0, 1, 1, 1, 1, 0, 4'hD, BOOT, 0, 0, 0);
    cyc("reboot1",     0, 0, 0, 0, 0, 0, 4'hD, BOOT, 1, 0, 0);
    cyc("reboot2",     0, 0, 0, 0, 0, 0, 4'hC, RUN,  2, 0, 0);

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl_sequencer.md
Name: pipeline_ctrl_sequencer

Overview:
Central pipeline-control sequencer for the 5-stage RV32 core. It owns the boot counter consumed by the hazard detection unit and arbitrates the competing hold and kill requests: load-use stall, branch mispredict and memory wait. From these it drives the per-stage enables and flushes for PC, IF/ID and ID/EX. It also keeps stall and flush event counters for performance debug.

Parameters:
FLUSH_CYCLES, 2, cycles of IF/ID + ID/EX flush after a mispredict (legal range 1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
stall_ctrl  input  1  load-use/branch bubble request from the hazard detection unit
stall_cnt  input  1  countable load-use stall qualifier from the hazard detection unit
mispredict  input  1  EX/MEM branch resolved wrong (we_were_wrong & branch)
mem_busy  input  1  data memory not ready; whole pipe must freeze
cnt_clr  input  1  synchronous clear of the perf counters
boot_cnt  output  2  saturating boot counter fed to the hazard detection unit
pc_en  output  1  PC register load enable
if_id_en  output  1  IF/ID register enable
if_id_flush  output  1  IF/ID contents become NOP
id_ex_flush  output  1  ID/EX contents become bubble
ctrl_state  output  2  current state: 0 BOOT, 1 RUN, 2 FLUSH, 3 WAIT_MEM
stall_events  output  CNT_W  counted load-use stalls
flush_events  output  CNT_W  counted accepted mispredicts

Behaviour:
- Reset (rst=1 at posedge):
  - state=BOOT, boot_cnt=0, flush_cnt=0, pending_mp=0, both counters=0.
  - While rst is high, combinational outputs are pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1.
  - Reset mid-operation aborts any FLUSH/WAIT_MEM with no residue.
- boot_cnt: increments every cycle after reset, saturates at 3, is never cleared except by rst.
- Stage outputs are combinational from state and inputs (same-cycle effect). All other outputs are registered.
- BOOT:
  - Outputs: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_flush=1.
  - All request inputs are ignored.
  - Transition to RUN on the cycle boot_cnt==1, so RUN begins when boot_cnt==2.
- RUN, fixed priority mispredict > mem_busy > stall_ctrl:
  - mispredict:
    - Outputs: pc_en=1 (loads redirect target), if_id_en=1, if_id_flush=1, id_ex_flush=1.
    - flush_events+1.
    - If FLUSH_CYCLES>1: go to FLUSH with flush_cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
  - mem_busy: all enables 0, all flushes 0; go to WAIT_MEM.
  - stall_ctrl:
    - Outputs: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_flush=1.
    - stall_events+1 if stall_cnt=1.
  - none: pc_en=1, if_id_en=1, flushes 0.
- FLUSH:
  - If mem_busy: all enables 0, flushes 0, flush_cnt holds, state holds.
  - Otherwise: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1, flush_cnt-1. Go to RUN when flush_cnt==1 is consumed.
  - mispredict and stall_ctrl are ignored (wrong path); nothing is counted.
- WAIT_MEM:
  - While mem_busy=1: all enables 0, flushes 0; mispredict=1 sets pending_mp.
  - In the cycle mem_busy=0: evaluate exactly as RUN using mispredict|pending_mp, then clear pending_mp.
- Counters:
  - Wrap modulo 2^CNT_W.
  - cnt_clr zeroes both counters and wins over a same-cycle increment.
- stall_cnt without stall_ctrl is not counted. Counting requires the stall branch of RUN to be taken.
- Invariant: no cycle has pc_en=1 with if_id_en=0.

Test Plan:
- Reset then idle inputs:
  - boot_cnt 0,1,2,3,3.
  - ctrl_state BOOT,BOOT,RUN.
  - id_ex_flush=1 for exactly 2 cycles; pc_en=1 from cycle 0.
- RUN, stall_ctrl=stall_cnt=1 for 1 cycle:
  - That cycle pc_en=0, if_id_en=0, id_ex_flush=1.
  - stall_events=1 next cycle; normal flow resumes.
- RUN, 1-cycle mispredict, FLUSH_CYCLES=2:
  - if_id_flush=id_ex_flush=1 for 2 consecutive cycles.
  - States RUN, FLUSH, RUN; flush_events=1.
- Simultaneous mispredict+mem_busy+stall_ctrl in RUN:
  - Mispredict response taken.
  - flush_events+1, stall_events unchanged.
- mem_busy high 3 cycles, mispredict pulsed in WAIT_MEM cycle 2:
  - Enables 0 for 3 cycles.
  - On release cycle, flush outputs asserted and state goes to FLUSH; flush_events=1.
- rst asserted while in FLUSH with flush_cnt=1:
  - Next cycle state=BOOT, boot_cnt=0, counters 0.
  - cnt_clr with a same-cycle stall leaves stall_events=0.
